// File: rtl/match_pkg.sv
// Shared definitions for the light-cycle match controller: state encoding,
// USB keycodes of interest and a small one-hot helper.
package match_pkg;

  typedef enum logic [2:0] {
    MENU          = 3'd0,
    ROUND_PAUSED  = 3'd1,
    ROUND_STARTED = 3'd2,
    ROUND_OVER    = 3'd3,
    MATCH_OVER    = 3'd4
  } game_state_e;

  localparam logic [7:0] KEY_ENTER      = 8'h28;
  localparam logic [7:0] KEY_UP_W       = 8'h1A;
  localparam logic [7:0] KEY_UP_ARROW   = 8'h52;
  localparam logic [7:0] KEY_DOWN_S     = 8'h16;
  localparam logic [7:0] KEY_DOWN_ARROW = 8'h51;

  localparam int MAX_PLAYERS = 4;

  // True when exactly one rider is left standing.
  function automatic logic is_one_hot(input logic [MAX_PLAYERS-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bus between the game logic and the match controller: keyboard, frame and
// collision inputs plus the game-state outputs consumed by the renderer.
interface match_controller_if #(
  parameter int NUM_PLAYERS = 2
);

  logic                       frame_tick;
  logic [7:0]                 keycode;
  logic [NUM_PLAYERS-1:0]     crash;
  logic [2:0]                 Game_State;
  logic [2:0]                 map_select;
  logic                       load_background;
  logic [NUM_PLAYERS-1:0]     alive;
  logic [3*NUM_PLAYERS-1:0]   scores;
  logic [1:0]                 winner;

  modport master (
    output frame_tick, keycode, crash,
    input  Game_State, map_select, load_background, alive, scores, winner
  );

  modport slave (
    input  frame_tick, keycode, crash,
    output Game_State, map_select, load_background, alive, scores, winner
  );

endinterface

// File: rtl/match_controller_key_edge_detect.sv
// Turns the level-valued USB keycode into one-cycle press pulses: a key counts
// only on the cycle its code first appears.
module key_edge_detect
  import match_pkg::*;
(
  input  logic       Clk,
  input  logic       rst,
  input  logic [7:0] keycode,
  output logic       enter_press,
  output logic       up_press,
  output logic       down_press
);

  logic [7:0] prev_keycode_r;
  logic       new_key_s;

  // Remember last cycle's keycode so a held key fires once
  always_ff @(posedge Clk) begin
    if (rst) begin
      prev_keycode_r <= 8'h00;
    end else begin
      prev_keycode_r <= keycode;
    end
  end

  assign new_key_s   = (keycode != prev_keycode_r);
  assign enter_press = new_key_s && (keycode == KEY_ENTER);
  assign up_press    = new_key_s && ((keycode == KEY_UP_W) || (keycode == KEY_UP_ARROW));
  assign down_press  = new_key_s && ((keycode == KEY_DOWN_S) || (keycode == KEY_DOWN_ARROW));

endmodule

// File: rtl/match_controller.sv
// Match controller: menu/map selection, round sequencing, scoring and winner.
// Optional MATCH_TIMEOUT_EN adds a frame counter that forces a drawn round.
module match_controller
  import match_pkg::*;
#(
  parameter int          NUM_PLAYERS    = 2,
  parameter int          ROUNDS_TO_WIN  = 3,
  parameter int          NUM_MAPS       = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd600
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Reset_Game,
  match_controller_if.slave  bus
);

  localparam logic [NUM_PLAYERS-1:0] ALL_ALIVE = {NUM_PLAYERS{1'b1}};
  localparam logic [NUM_PLAYERS-1:0] NONE_ALIVE = {NUM_PLAYERS{1'b0}};
  localparam logic [2:0]             LAST_MAP  = 3'(NUM_MAPS - 1);
  localparam logic [2:0]             WIN_SCORE = 3'(ROUNDS_TO_WIN);

  logic                      rst_s;
  logic                      enter_press_s;
  logic                      up_press_s;
  logic                      down_press_s;

  game_state_e               state_r,  state_nxt_s;
  logic [2:0]                map_r,    map_nxt_s;
  logic [3*NUM_PLAYERS-1:0]  scores_r, scores_nxt_s;
  logic [NUM_PLAYERS-1:0]    alive_r,  alive_nxt_s;
  logic [1:0]                winner_r, winner_nxt_s;
  logic                      load_bg_r, load_bg_nxt_s;
  logic                      win_hit_s;
  logic [1:0]                win_idx_s;

  assign rst_s = Reset | Reset_Game;

  key_edge_detect u_key_edge (
    .Clk         (Clk),
    .rst         (rst_s),
    .keycode     (bus.keycode),
    .enter_press (enter_press_s),
    .up_press    (up_press_s),
    .down_press  (down_press_s)
  );

`ifdef MATCH_TIMEOUT_EN
  logic [31:0] timeout_cnt_r, timeout_cnt_nxt_s;
`else
  logic unused_s;
  assign unused_s = ^{bus.frame_tick, TIMEOUT_CYCLES};
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s   = state_r;
    map_nxt_s     = map_r;
    scores_nxt_s  = scores_r;
    alive_nxt_s   = alive_r;
    winner_nxt_s  = winner_r;
    load_bg_nxt_s = 1'b0;
    win_hit_s     = 1'b0;
    win_idx_s     = 2'd0;
`ifdef MATCH_TIMEOUT_EN
    timeout_cnt_nxt_s = 32'd0;
`endif

    // Descending scan so the lowest index wins if several could qualify
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (scores_r[3*i +: 3] == WIN_SCORE) begin
        win_hit_s = 1'b1;
        win_idx_s = 2'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end

    case (state_r)
      MENU: begin
        if (enter_press_s) begin
          state_nxt_s   = ROUND_PAUSED;
          scores_nxt_s  = '0;
          alive_nxt_s   = ALL_ALIVE;
          load_bg_nxt_s = 1'b1;
        end else if (up_press_s) begin
          map_nxt_s = (map_r == LAST_MAP) ? 3'd0 : map_r + 3'd1;
        end else if (down_press_s) begin
          map_nxt_s = (map_r == 3'd0) ? LAST_MAP : map_r - 3'd1;
        end else begin
          map_nxt_s = map_r;
        end
      end

      ROUND_PAUSED: begin
        if (enter_press_s) begin
          state_nxt_s = ROUND_STARTED;
        end else begin
          state_nxt_s = ROUND_PAUSED;
        end
      end

      ROUND_STARTED: begin
        // Round end is judged on the registered alive vector, one cycle after the crash
        if (is_one_hot(MAX_PLAYERS'(alive_r))) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_r[i] && (scores_r[3*i +: 3] < WIN_SCORE)) begin
              scores_nxt_s[3*i +: 3] = scores_r[3*i +: 3] + 3'd1;
            end else begin
              scores_nxt_s[3*i +: 3] = scores_r[3*i +: 3];
            end
          end
          state_nxt_s = ROUND_OVER;
        end else if (alive_r == NONE_ALIVE) begin
          state_nxt_s = ROUND_OVER;
`ifdef MATCH_TIMEOUT_EN
        end else if (timeout_cnt_r == TIMEOUT_CYCLES) begin
          state_nxt_s = ROUND_OVER;
`endif
        end else begin
          alive_nxt_s = alive_r & ~bus.crash;
`ifdef MATCH_TIMEOUT_EN
          timeout_cnt_nxt_s = timeout_cnt_r + {31'd0, bus.frame_tick};
`endif
        end
      end

      ROUND_OVER: begin
        if (enter_press_s) begin
          load_bg_nxt_s = 1'b1;
          if (win_hit_s) begin
            state_nxt_s  = MATCH_OVER;
            winner_nxt_s = win_idx_s;
          end else begin
            state_nxt_s = ROUND_PAUSED;
            alive_nxt_s = ALL_ALIVE;
          end
        end else begin
          state_nxt_s = ROUND_OVER;
        end
      end

      MATCH_OVER: begin
        if (enter_press_s) begin
          state_nxt_s   = MENU;
          load_bg_nxt_s = 1'b1;
        end else begin
          state_nxt_s = MATCH_OVER;
        end
      end

      default: begin
        state_nxt_s = MENU;
      end
    endcase
  end

  // State register and registered outputs; reset outranks any same-cycle event
  always_ff @(posedge Clk) begin
    if (rst_s) begin
      state_r   <= MENU;
      map_r     <= 3'd0;
      scores_r  <= '0;
      alive_r   <= ALL_ALIVE;
      winner_r  <= 2'd0;
      load_bg_r <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
      timeout_cnt_r <= 32'd0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      map_r     <= map_nxt_s;
      scores_r  <= scores_nxt_s;
      alive_r   <= alive_nxt_s;
      winner_r  <= winner_nxt_s;
      load_bg_r <= load_bg_nxt_s;
`ifdef MATCH_TIMEOUT_EN
      timeout_cnt_r <= timeout_cnt_nxt_s;
`endif
    end
  end

  assign bus.Game_State      = state_r;
  assign bus.map_select      = map_r;
  assign bus.scores          = scores_r;
  assign bus.alive           = alive_r;
  assign bus.winner          = winner_r;
  assign bus.load_background = load_bg_r;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: a behavioural model queues the
// expected outputs per cycle, each scenario task drains and compares them.
module tb_match_controller;
  import match_pkg::*;

  localparam int NP  = 2;
  localparam int RTW = 3;
  localparam int NM  = 3;
`ifdef MATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] map;
    logic [5:0] sc;
    logic [1:0] al;
    logic [1:0] win;
    logic       lb;
  } out_t;

  logic Clk = 1'b0;
  logic Reset;
  logic Reset_Game;
  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];
  out_t obs_q[$];
  out_t rst_exp;

  logic [2:0] m_state;
  logic [2:0] m_map;
  logic [2:0] m_sc [NP];
  logic [1:0] m_alive;
  logic [1:0] m_win;
  logic       m_lb;
  logic [7:0] m_prev;
  int         m_cnt;

  always #5 Clk = ~Clk;

  match_controller_if #(.NUM_PLAYERS(NP)) bus ();

  match_controller #(
    .NUM_PLAYERS   (NP),
    .ROUNDS_TO_WIN (RTW),
    .NUM_MAPS      (NM),
    .TIMEOUT_CYCLES(32'd5)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Reset_Game (Reset_Game),
    .bus        (bus.slave)
  );

  function automatic out_t observe();
    out_t o;
    o = {bus.Game_State, bus.map_select, bus.scores, bus.alive, bus.winner, bus.load_background};
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o = {m_state, m_map, m_sc[1], m_sc[0], m_alive, m_win, m_lb};
    return o;
  endfunction

  function automatic void model_step(input logic [7:0] kc, input logic [1:0] cr,
                                     input logic tk, input logic rs);
    logic pe, pu, pd, hit;
    logic [1:0] idx;
    pe = (kc == KEY_ENTER) && (kc != m_prev);
    pu = ((kc == KEY_UP_W) || (kc == KEY_UP_ARROW)) && (kc != m_prev);
    pd = ((kc == KEY_DOWN_S) || (kc == KEY_DOWN_ARROW)) && (kc != m_prev);
    if (rs) begin
      m_state = 3'd0; m_map = 3'd0; m_sc = '{default: 3'd0}; m_alive = 2'b11;
      m_win = 2'd0; m_lb = 1'b0; m_prev = 8'h00; m_cnt = 0;
      return;
    end
    m_prev = kc;
    m_lb   = 1'b0;
    case (m_state)
      3'd0: begin
        if (pe) begin
          m_state = 3'd1; m_sc = '{default: 3'd0}; m_alive = 2'b11; m_lb = 1'b1;
        end else if (pu) m_map = (m_map == 3'(NM - 1)) ? 3'd0 : m_map + 3'd1;
        else if (pd) m_map = (m_map == 3'd0) ? 3'(NM - 1) : m_map - 3'd1;
      end
      3'd1: if (pe) begin m_state = 3'd2; m_cnt = 0; end
      3'd2: begin
        if ($countones(m_alive) == 1) begin
          for (int i = 0; i < NP; i++)
            if (m_alive[i] && m_sc[i] < 3'(RTW)) m_sc[i] = m_sc[i] + 3'd1;
          m_state = 3'd3;
        end else if (m_alive == 2'b00) m_state = 3'd3;
        else if (TO_EN && m_cnt == 5) m_state = 3'd3;
        else begin
          m_alive = m_alive & ~cr;
          m_cnt   = m_cnt + int'(tk);
        end
      end
      3'd3: begin
        if (pe) begin
          hit = 1'b0; idx = 2'd0;
          for (int i = 0; i < NP; i++)
            if (!hit && m_sc[i] == 3'(RTW)) begin hit = 1'b1; idx = 2'(i); end
          if (hit) begin m_state = 3'd4; m_win = idx; end
          else begin m_state = 3'd1; m_alive = 2'b11; end
          m_lb = 1'b1;
        end
      end
      3'd4: if (pe) begin m_state = 3'd0; m_lb = 1'b1; end
      default: m_state = 3'd0;
    endcase
  endfunction

  task automatic tick(input logic [7:0] kc, input logic [1:0] cr = 2'b00, input logic tk = 1'b0,
                      input logic rs = 1'b0, input logic rg = 1'b0);
    @(negedge Clk);
    bus.keycode = kc; bus.crash = cr; bus.frame_tick = tk; Reset = rs; Reset_Game = rg;
    model_step(kc, cr, tk, rs | rg);
    exp_q.push_back(model_out());
    @(posedge Clk);
    #1;
    obs_q.push_back(observe());
  endtask

  task automatic test_reset();
    out_t o, e;
    tick(8'h00, 2'b00, 1'b0, 1'b1);
    tick(8'h00, 2'b00, 1'b0, 1'b1);
    o = observe(); checks++;
    if (o !== rst_exp) begin errors++; $display("FAIL reset_values: got %h expected %h", o, rst_exp); end
    tick(8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_map_select();
    out_t o, e;
    logic [2:0] exp_down [3] = '{3'd2, 3'd1, 3'd0};
    logic [7:0] up_keys  [4] = '{KEY_UP_W, KEY_UP_ARROW, KEY_UP_W, KEY_UP_ARROW};
    logic [2:0] exp_up   [4] = '{3'd1, 3'd2, 3'd0, 3'd1};
    for (int k = 0; k < 3; k++) begin
      tick(KEY_DOWN_S);
      o = observe(); checks++;
      if (o.map !== exp_down[k]) begin errors++; $display("FAIL down_press%0d: map_select=%0d expected %0d", k, o.map, exp_down[k]); end
      tick(8'h00);
    end
    // Alternating codes back to back: each code change is a fresh press
    for (int k = 0; k < 4; k++) begin
      tick(up_keys[k]);
      o = observe(); checks++;
      if (o.map !== exp_up[k]) begin errors++; $display("FAIL up_press%0d: map_select=%0d expected %0d", k, o.map, exp_up[k]); end
    end
    tick(KEY_DOWN_ARROW);
    tick(KEY_DOWN_ARROW);
    tick(KEY_UP_W);
    tick(8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL map_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_enter_hold();
    out_t o, e;
    int lb_cnt = 0;
    int tr_cnt = 0;
    logic [2:0] prev_st;
    prev_st = observe().st;
    for (int k = 0; k < 10; k++) begin
      tick(KEY_ENTER);
      o = observe();
      if (o.lb) lb_cnt++;
      if (o.st == 3'd1 && prev_st == 3'd0) tr_cnt++;
      prev_st = o.st;
    end
    checks++;
    if (lb_cnt != 1) begin errors++; $display("FAIL enter_hold_lb: pulses=%0d expected 1", lb_cnt); end
    checks++;
    if (tr_cnt != 1 || prev_st !== 3'd1) begin errors++; $display("FAIL enter_hold_state: transitions=%0d state=%0d expected 1/1", tr_cnt, prev_st); end
    tick(8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL enter_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_round_crash();
    out_t o, e;
    tick(KEY_ENTER);
    tick(8'h00);
    tick(8'h00, 2'b01);
    o = observe(); checks++;
    if (o.al !== 2'b10 || o.st !== 3'd2) begin errors++; $display("FAIL crash_alive: alive=%b state=%0d expected 10/2", o.al, o.st); end
    tick(8'h00);
    o = observe(); checks++;
    if (o.st !== 3'd3 || o.sc !== 6'b001_000) begin errors++; $display("FAIL crash_score: state=%0d scores=%b expected 3/001000", o.st, o.sc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL crash_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_draw();
    out_t o, e;
    tick(KEY_ENTER);
    o = observe(); checks++;
    if (o.st !== 3'd1 || o.al !== 2'b11 || o.lb !== 1'b1) begin errors++; $display("FAIL next_round: state=%0d alive=%b lb=%b expected 1/11/1", o.st, o.al, o.lb); end
    tick(8'h00);
    tick(KEY_ENTER);
    tick(8'h00);
    tick(8'h00, 2'b11);
    tick(8'h00);
    o = observe(); checks++;
    if (o.st !== 3'd3 || o.al !== 2'b00 || o.sc !== 6'b001_000) begin errors++; $display("FAIL draw: state=%0d alive=%b scores=%b expected 3/00/001000", o.st, o.al, o.sc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL draw_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_match_win();
    out_t o, e;
    for (int r = 0; r < 2; r++) begin
      tick(KEY_ENTER);
      tick(8'h00);
      tick(KEY_ENTER);
      tick(8'h00);
      tick(8'h00, 2'b01);
      tick(8'h00, 2'b01);
    end
    tick(KEY_ENTER);
    o = observe(); checks++;
    if (o.st !== 3'd4 || o.win !== 2'd1 || o.lb !== 1'b1 || o.sc !== 6'b011_000) begin
      errors++; $display("FAIL match_over: state=%0d winner=%0d lb=%b scores=%b expected 4/1/1/011000", o.st, o.win, o.lb, o.sc);
    end
    tick(8'h00);
    tick(KEY_ENTER);
    o = observe(); checks++;
    if (o.st !== 3'd0 || o.lb !== 1'b1 || o.map !== 3'd1) begin errors++; $display("FAIL back_to_menu: state=%0d lb=%b map=%0d expected 0/1/1", o.st, o.lb, o.map); end
    tick(8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL match_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_midround();
    out_t o, e;
    tick(KEY_ENTER);
    tick(8'h00);
    tick(KEY_ENTER);
    tick(8'h00);
    tick(8'h00, 2'b01, 1'b0, 1'b1);
    o = observe(); checks++;
    if (o !== rst_exp) begin errors++; $display("FAIL reset_midround: got %h expected %h", o, rst_exp); end
    tick(8'h00);
    tick(KEY_ENTER);
    tick(8'h00);
    tick(KEY_ENTER, 2'b00, 1'b0, 1'b0, 1'b1);
    o = observe(); checks++;
    if (o !== rst_exp) begin errors++; $display("FAIL reset_game: got %h expected %h", o, rst_exp); end
    tick(KEY_ENTER);
    o = observe(); checks++;
    if (o.st !== 3'd1) begin errors++; $display("FAIL press_after_reset: state=%0d expected 1", o.st); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_sb: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    out_t o, e;
    tick(8'h00);
    tick(KEY_ENTER);
    tick(8'h00);
    for (int k = 0; k < 5; k++) tick(8'h00, 2'b00, 1'b1);
    tick(8'h00);
    o = observe(); checks++;
`ifdef MATCH_TIMEOUT_EN
    if (o.st !== 3'd3 || o.sc !== 6'd0) begin errors++; $display("FAIL timeout_draw: state=%0d scores=%b expected 3/000000", o.st, o.sc); end
`else
    if (o.st !== 3'd2 || o.al !== 2'b11) begin errors++; $display("FAIL no_timeout: state=%0d alive=%b expected 2/11", o.st, o.al); end
    tick(8'h00, 2'b10);
    tick(8'h00);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_sb: got %h expected %h", o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Reset_Game = 1'b0;
    bus.keycode = 8'h00; bus.crash = 2'b00; bus.frame_tick = 1'b0;
    rst_exp = {3'd0, 3'd0, 6'd0, 2'b11, 2'b00, 1'b0};
    test_reset();
    test_map_select();
    test_enter_hold();
    test_round_crash();
    test_draw();
    test_match_win();
    test_reset_midround();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of cycle riders (legal 2..4).
REQ-002 SHALL have parameter ROUNDS_TO_WIN, default 3, round wins needed to take the match (legal 1..7).
REQ-003 SHALL have parameter NUM_MAPS, default 3, number of selectable arenas (legal 1..8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd600, frames before forced draw; used only with MATCH_TIMEOUT_EN.
REQ-005 SHALL have port Clk, input, 1, sole clock.
REQ-006 SHALL have port Reset, input, 1; synchronous, active-high.
REQ-007 SHALL have port Reset_Game, input, 1; synchronous, active-high; same effect as Reset.
REQ-008 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have port keycode, input, 8, current USB keycode.
REQ-010 SHALL have port crash, input, NUM_PLAYERS, per-player collision pulse.
REQ-011 SHALL have port Game_State, output, 3, encoded current state.
REQ-012 SHALL have port map_select, output, 3, selected arena index.
REQ-013 SHALL have port load_background, output, 1, one-cycle background reload pulse.
REQ-014 SHALL have port alive, output, NUM_PLAYERS, riders still in the round.
REQ-015 SHALL have port scores, output, 3*NUM_PLAYERS, packed round-win counts, player 0 in LSBs.
REQ-016 SHALL have port winner, output, 2, match winner index, valid in MATCH_OVER.

Function
REQ-017 SHALL act on key presses only: press = keycode equals target AND keycode differs from previous-cycle keycode.
REQ-018 SHALL implement states MENU(0), ROUND_PAUSED(1), ROUND_STARTED(2), ROUND_OVER(3), MATCH_OVER(4); Game_State SHALL equal the current state.
REQ-019 MENU: up press (0x1A or 0x52) SHALL increment map_select, wrapping NUM_MAPS-1 to 0; down press (0x16 or 0x51) SHALL decrement, wrapping 0 to NUM_MAPS-1; simultaneous up and down impossible (single keycode).
REQ-020 MENU + Enter press (0x28) SHALL go to ROUND_PAUSED, clear all scores, set alive all-ones, pulse load_background.
REQ-021 ROUND_PAUSED + Enter press SHALL go to ROUND_STARTED.
REQ-022 ROUND_STARTED: a crash bit SHALL clear its alive bit the same edge; crash on an already-dead rider SHALL be ignored.
REQ-023 When alive has exactly one bit set, that player's score SHALL increment by 1 and state SHALL go to ROUND_OVER next cycle.
REQ-024 When alive becomes zero (simultaneous final crashes), no score SHALL change (draw) and state SHALL go to ROUND_OVER.
REQ-025 ROUND_OVER + Enter press: if any score equals ROUNDS_TO_WIN, go to MATCH_OVER with winner set to that index; else go to ROUND_PAUSED, alive all-ones; load_background SHALL pulse in both cases.
REQ-026 MATCH_OVER + Enter press SHALL go to MENU, pulse load_background, map_select unchanged.
REQ-027 Scores SHALL saturate at ROUNDS_TO_WIN.
REQ-028 Unused Game_State encodings SHALL return to MENU next cycle.

Reset
REQ-029 On Reset or Reset_Game: state MENU, map_select 0, scores 0, alive all-ones, winner 0, load_background 0, previous keycode 0, timeout counter 0.
REQ-030 Reset mid-round SHALL override any crash or key event in the same cycle.

Configuration
REQ-031 With MATCH_TIMEOUT_EN defined, a frame counter SHALL count frame_tick in ROUND_STARTED, clear on entry, and on reaching TIMEOUT_CYCLES force a draw into ROUND_OVER; a same-cycle last-survivor condition SHALL take priority.
REQ-032 Without MATCH_TIMEOUT_EN, no counter SHALL exist and rounds end only by crashes.

Structure
REQ-033 Package match_pkg SHALL hold the state enum and key constants KEY_ENTER, KEY_UP_W, KEY_UP_ARROW, KEY_DOWN_S, KEY_DOWN_ARROW.
REQ-034 Press detection SHALL be sub-module key_edge_detect (keycode in, per-key press pulses out).

Verification
REQ-035 NUM_MAPS=3, MENU, three down presses -> map_select 2,1,0.
REQ-036 Enter held 10 cycles in MENU -> exactly one transition to ROUND_PAUSED, one load_background pulse.
REQ-037 Round started, crash=2'b01 -> alive 2'b10, scores[5:3]=1, ROUND_OVER.
REQ-038 crash=2'b11 same cycle -> alive 0, scores unchanged, ROUND_OVER.
REQ-039 ROUNDS_TO_WIN=3, player 1 wins three rounds -> MATCH_OVER, winner 1; Enter -> MENU.
REQ-040 MATCH_TIMEOUT_EN, TIMEOUT_CYCLES=5, five frame_ticks without crash -> ROUND_OVER, scores unchanged; Reset asserted mid-round -> MENU, all outputs at reset values.
